// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width constants for the restoring divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;

  // Counter must reach WIDTH itself, so it needs one bit beyond log2.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/divider_datapath.sv
// rtl/divider_datapath.sv - restoring shift/subtract divider datapath, sequenced by an external controller.
module divider_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             initialize,
  input  logic             load_divident,
  input  logic             sh_en,
  output logic             divident_gt_divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0] QUO_MSB = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

  logic [2*WIDTH-1:0] rem_q, rem_d;
  logic [2*WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               dz_q,  dz_d;

  assign done      = (cnt_q == CNT_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q[WIDTH-1:0];
  assign div_by_zero = dz_q;
  // A zero aligned divisor (reset, or divide-by-zero) must never request a subtract.
  assign divident_gt_divisor = (dvs_q != '0) && (rem_q >= dvs_q);

  always_comb begin
    rem_d = rem_q;
    dvs_d = dvs_q;
    quo_d = quo_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    if (initialize) begin
      rem_d = {{WIDTH{1'b0}}, dividend};
      dvs_d = {{WIDTH{1'b0}}, divisor} << (WIDTH-1);
      quo_d = '0;
      cnt_d = '0;
      dz_d  = (divisor == '0);
    end else if (!done) begin
      if (load_divident) begin
        rem_d = rem_q - dvs_q;
        quo_d = quo_q | (QUO_MSB >> cnt_q);
      end else if (sh_en) begin
        dvs_d = dvs_q >> 1;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_q <= '0;
      dvs_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

endmodule

// File: tb/tb_divider_datapath.sv
// tb/tb_divider_datapath.sv - directed self-checking bench for divider_datapath.
module tb_divider_datapath;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        initialize;
  logic        load_divident;
  logic        sh_en;
  logic        divident_gt_divisor;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  divider_datapath #(.WIDTH(32)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .dividend            (dividend),
    .divisor             (divisor),
    .initialize          (initialize),
    .load_divident       (load_divident),
    .sh_en               (sh_en),
    .divident_gt_divisor (divident_gt_divisor),
    .done                (done),
    .quotient            (quotient),
    .remainder           (remainder),
    .div_by_zero         (div_by_zero)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; outputs are read there too.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_div(input logic [31:0] a, input logic [31:0] b,
                           input logic ld, input logic sh);
    dividend = a;
    divisor = b;
    initialize = 1'b1;
    load_divident = ld;
    sh_en = sh;
    tick();
    initialize = 1'b0;
    load_divident = 1'b0;
    sh_en = 1'b0;
  endtask

  // Acts as the controller: subtract when possible, otherwise shift.
  task automatic run_ctrl(output int cycles, output bit gt_seen);
    cycles = 0;
    gt_seen = 1'b0;
    while (!done && cycles < 200) begin
      if (divident_gt_divisor) gt_seen = 1'b1;
      load_divident = divident_gt_divisor;
      sh_en = !divident_gt_divisor;
      tick();
      cycles++;
    end
    load_divident = 1'b0;
    sh_en = 1'b0;
  endtask

  task automatic step_ctrl(input int n);
    for (int i = 0; i < n; i++) begin
      load_divident = divident_gt_divisor;
      sh_en = !divident_gt_divisor;
      tick();
    end
    load_divident = 1'b0;
    sh_en = 1'b0;
  endtask

  task automatic check_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input int exp_cyc, input logic exp_dz);
    int cyc;
    bit gt_seen;
    start_div(a, b, 1'b0, 1'b0);
    run_ctrl(cyc, gt_seen);
    checks++;
    if (quotient !== exp_q) begin
      errors++;
      $display("FAIL %s quotient: got %h expected %h", name, quotient, exp_q);
    end
    checks++;
    if (remainder !== exp_r) begin
      errors++;
      $display("FAIL %s remainder: got %h expected %h", name, remainder, exp_r);
    end
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_cyc);
    end
    checks++;
    if (div_by_zero !== exp_dz) begin
      errors++;
      $display("FAIL %s div_by_zero: got %b expected %b", name, div_by_zero, exp_dz);
    end
    if (exp_dz) begin
      checks++;
      if (gt_seen) begin
        errors++;
        $display("FAIL %s gt_never_set: got 1 expected 0", name);
      end
    end
  endtask

  task automatic check_zero_outputs(input string name);
    checks++;
    if ({quotient, remainder, done, div_by_zero, divident_gt_divisor} !== '0) begin
      errors++;
      $display("FAIL %s: got q=%h r=%h done=%b dz=%b gt=%b expected all 0",
               name, quotient, remainder, done, div_by_zero, divident_gt_divisor);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    initialize = 1'b1;
    dividend = 32'd9;
    divisor = 32'd3;
    load_divident = 1'b1;
    sh_en = 1'b1;
    tick();
    tick();
    check_zero_outputs("reset_state");
    initialize = 1'b0;
    load_divident = 1'b0;
    sh_en = 1'b0;
    RST = 1'b0;
    tick();
    check_zero_outputs("reset_idle_hold");
  endtask

  task automatic test_divisions();
    check_div("100_div_7", 32'd100, 32'd7, 32'd14, 32'd2, 35, 1'b0);
    check_div("max_div_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 64, 1'b0);
    check_div("3_div_10", 32'd3, 32'd10, 32'd0, 32'd3, 32, 1'b0);
    check_div("5_div_0", 32'd5, 32'd0, 32'd0, 32'd5, 32, 1'b1);
  endtask

  task automatic test_hold_after_done();
    check_div("hold_setup_23_div_4", 32'd23, 32'd4, 32'd5, 32'd3, 34, 1'b0);
    load_divident = 1'b1;
    sh_en = 1'b1;
    tick();
    tick();
    tick();
    load_divident = 1'b0;
    sh_en = 1'b0;
    checks++;
    if (quotient !== 32'd5 || remainder !== 32'd3 || done !== 1'b1) begin
      errors++;
      $display("FAIL hold_after_done: got q=%0d r=%0d done=%b expected q=5 r=3 done=1",
               quotient, remainder, done);
    end
  endtask

  task automatic test_reset_mid();
    start_div(32'd100, 32'd7, 1'b0, 1'b0);
    step_ctrl(10);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_zero_outputs("reset_mid_op");
    check_div("after_reset_50_div_5", 32'd50, 32'd5, 32'd10, 32'd0, 34, 1'b0);
  endtask

  task automatic test_abort_restart();
    int cyc;
    bit gt_seen;
    start_div(32'd100, 32'd7, 1'b0, 1'b0);
    step_ctrl(5);
    start_div(32'd81, 32'd9, 1'b1, 1'b1);
    run_ctrl(cyc, gt_seen);
    checks++;
    if (quotient !== 32'd9 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL abort_restart result: got q=%0d r=%0d expected q=9 r=0", quotient, remainder);
    end
    checks++;
    if (cyc != 34) begin
      errors++;
      $display("FAIL abort_restart latency: got %0d expected 34", cyc);
    end
  endtask

  // 0x80000000/1: first step subtracts; load+sh together must not also shift.
  task automatic test_load_priority();
    int cyc;
    bit gt_seen;
    start_div(32'h8000_0000, 32'd1, 1'b0, 1'b0);
    load_divident = 1'b1;
    sh_en = 1'b1;
    tick();
    load_divident = 1'b0;
    sh_en = 1'b0;
    checks++;
    if (quotient !== 32'h8000_0000 || remainder !== 32'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_priority step: got q=%h r=%h done=%b expected q=80000000 r=0 done=0",
               quotient, remainder, done);
    end
    run_ctrl(cyc, gt_seen);
    checks++;
    if (cyc != 32 || quotient !== 32'h8000_0000) begin
      errors++;
      $display("FAIL load_priority remaining: got cycles=%0d q=%h expected cycles=32 q=80000000",
               cyc, quotient);
    end
  endtask

  initial begin
    RST = 1'b1;
    dividend = '0;
    divisor = '0;
    initialize = 1'b0;
    load_divident = 1'b0;
    sh_en = 1'b0;
    test_reset();
    test_divisions();
    test_hold_after_done();
    test_reset_mid();
    test_abort_restart();
    test_load_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
